seq_shift_add_multiplier: RTL and testbench



---
 rtl/seq_shift_add_multiplier.sv | 90 +++++++++
 tb/tb_seq_shift_add_multiplier.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned shift-and-add sequential multiplier.
// One add-and-shift iteration per clock; product appears WIDTH edges after
// the start edge, with a single-cycle done pulse.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_reg;
  logic [2*WIDTH:0]   acc;      // {carry/high half, low half holding multiplier bits}
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_nxt;
  logic               last_iter;

  // One iteration: conditional (WIDTH+1)-bit add into the high part, then a
  // combined right shift so the carry drops into the top of the product.
  always_comb begin
    sum       = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, a_reg} : '0);
    acc_nxt   = {1'b0, sum, acc[WIDTH-1:1]};
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs; DONE lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (last_iter) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture on start, iterate in CALC, publish product on the last iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_reg <= multiplicand;
          acc   <= {{(WIDTH+1){1'b0}}, multiplier};
          cnt   <= '0;
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (last_iter) product <= acc_nxt[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed/table-driven bench for seq_shift_add_multiplier (WIDTH=8).
module tb_seq_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           busy, done;
  logic [2*W-1:0] product;

  int compared = 0;
  int mismatched = 0;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Continuous protocol monitor, sampled on the falling edge.
  int   rst_cnt = 0;
  int   rst_seen = 0;
  logic prev_done = 1'b0;
  logic [2*W-1:0] prev_p = '0;
  always @(posedge reset) rst_cnt++;
  always @(negedge clk) begin
    check("busy_and_done_exclusive", {31'b0, busy & done}, 32'd0);
    check("done_single_cycle", {31'b0, done & prev_done}, 32'd0);
    if (rst_cnt == rst_seen && !done)
      check("product_stable", {16'b0, product}, {16'b0, prev_p});
    rst_seen  = rst_cnt;
    prev_done = done;
    prev_p    = product;
  end

  // Single operation: pulse start for one edge, expect done exactly W edges later.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string name);
    int lat;
    @(negedge clk);
    multiplicand = a; multiplier = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    multiplicand = ~a; multiplier = ~b;   // inputs wander after capture
    check({name, "_busy_after_start"}, {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, W);
    check({name, "_product"}, {16'b0, product}, {16'b0, exp});
    check({name, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check({name, "_done_cleared"}, {31'b0, done}, 32'd0);
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int k;
    logic [W-1:0] ra, rb;
    vecs[0] = '{8'd13,  8'd11,  16'd143};
    vecs[1] = '{8'd255, 8'd255, 16'd65025};
    vecs[2] = '{8'd0,   8'd200, 16'd0};
    vecs[3] = '{8'd200, 8'd0,   16'd0};
    vecs[4] = '{8'd1,   8'd1,   16'd1};
    vecs[5] = '{8'd255, 8'd1,   16'd255};
    vecs[6] = '{8'd1,   8'd255, 16'd255};
    vecs[7] = '{8'd128, 8'd2,   16'd256};
    vecs[8] = '{8'd170, 8'd85,  16'd14450};
    vecs[9] = '{8'd15,  8'd17,  16'd255};

    #1 reset = 1'b1;
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_product", {16'b0, product}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("idle_no_start_busy", {31'b0, busy}, 32'd0);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // Back-to-back with start held high; operands change mid-operation.
    @(negedge clk);
    multiplicand = 8'd3; multiplier = 8'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    multiplicand = 8'd7; multiplier = 8'd9;
    k = 0;
    while (!done && k < 30) begin @(posedge clk); #1; k++; end
    check("b2b_first_seen", k, W);
    check("b2b_first_product", {16'b0, product}, 32'd15);
    @(posedge clk); #1;   // back in IDLE; start still high, accepted at next edge
    @(posedge clk); #1;
    check("b2b_second_busy", {31'b0, busy}, 32'd1);
    multiplicand = 8'd1; multiplier = 8'd1;
    start = 1'b0;
    k = 0;
    while (!done && k < 30) begin @(posedge clk); #1; k++; end
    check("b2b_second_latency", k, W);
    check("b2b_second_product", {16'b0, product}, 32'd63);

    // Reset during the 4th CALC cycle.
    @(negedge clk);
    multiplicand = 8'd100; multiplier = 8'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_product", {16'b0, product}, 32'd0);
    #1 reset = 1'b0;
    k = 0;
    repeat (12) begin @(posedge clk); #1; if (done || busy) k++; end
    check("abort_no_done_or_busy", k, 0);
    run_op(8'd2, 8'd4, 16'd8, "after_abort");

    // Random pairs against A*B.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, 16'(ra) * 16'(rb), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
